// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the 7-segment display path. The display driver
// (encoder) and the scan decoder both import this package, so the code table
// cannot drift between them.
//   NUM_DIGITS  - digits per frame
//   BLANK_PAT   - active-low CAT value with every segment off
//   SEG_0..F    - active-high gfedcba segment codes per hex value
//   seg_code()  - nibble -> active-high segment code
//   an_class_e  - classification of a sampled anode vector
//   seg_dec_t   - result of decoding one CAT pattern
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] BLANK_PAT = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic [1:0] {
        AN_IDLE = 2'd0,
        AN_ONE  = 2'd1,
        AN_BAD  = 2'd2
    } an_class_e;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if
// Bundles the scanned display lines and the decoded-frame outputs.
//   SAMPLE_CE  - CAT/AN valid this cycle
//   CAT[6:0]   - segment lines, active-low, CAT[0]=a .. CAT[6]=g
//   AN[7:0]    - digit anodes, active-low
//   ERR_CLR    - clear sticky error flags
//   DIGITS     - decoded frame, digit i in DIGITS[4i+3:4i]
//   BLANK      - per-digit "last sample was blank"
//   FRAME_VLD  - one-cycle frame-complete pulse
//   FRAME_CNT  - completed frame count (wraps)
//   ERR_AN     - sticky: anode vector had more than one active digit
//   ERR_SEG    - sticky: segment pattern not in the code table
// master = side driving the display lines, slave = the decoder.
interface seg7_scan_decoder_if;

    logic        SAMPLE_CE;
    logic [6:0]  CAT;
    logic [7:0]  AN;
    logic        ERR_CLR;
    logic [31:0] DIGITS;
    logic [7:0]  BLANK;
    logic        FRAME_VLD;
    logic [7:0]  FRAME_CNT;
    logic        ERR_AN;
    logic        ERR_SEG;

    modport master (
        output SAMPLE_CE, CAT, AN, ERR_CLR,
        input  DIGITS, BLANK, FRAME_VLD, FRAME_CNT, ERR_AN, ERR_SEG
    );

    modport slave (
        input  SAMPLE_CE, CAT, AN, ERR_CLR,
        output DIGITS, BLANK, FRAME_VLD, FRAME_CNT, ERR_AN, ERR_SEG
    );

endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
// Combinational reverse lookup of an active-low CAT pattern.
//   cat[6:0] in  - active-low segment lines
//   dec      out - {valid, blank, nibble}; valid and blank are never both set,
//                  neither set means the pattern is unknown
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] cat,
    output seg_dec_t   dec
);

    logic [6:0] seg_on;

    assign seg_on = ~cat;

    always_comb begin
        dec = '0;
        if (cat == BLANK_PAT) begin
            dec.blank = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seg_on == seg_code(4'(i))) begin
                    dec.valid  = 1'b1;
                    dec.nibble = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Samples the multiplexed CAT/AN lines of the 8-digit display, decodes each
// lit digit back to a hex nibble and rebuilds the whole frame in parallel.
//   CLK  in  - system clock, rising edge
//   RST  in  - synchronous reset, active low
//   bus  slave modport of seg7_scan_decoder_if (display lines in, frame out)
// Pipeline: capture register -> commit (digits/blank/errors/seen) ->
// frame pulse and frame counter.
module seg7_scan_decoder
    import seg7_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    seg7_scan_decoder_if.slave   bus
);

    logic                    cap_vld;
    logic [6:0]              cap_cat;
    logic [NUM_DIGITS-1:0]   cap_an;

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   blank_q;
    logic [NUM_DIGITS-1:0]   seen;
    logic                    frame_pend;
    logic                    frame_vld_q;
    logic [7:0]              frame_cnt_q;
    logic                    err_an_q;
    logic                    err_seg_q;

    seg_dec_t                dec;
    an_class_e               an_class;
    logic [2:0]              an_idx;
    logic [3:0]              zero_cnt;

    logic                    commit;
    logic                    new_err_an;
    logic                    new_err_seg;
    logic                    frame_done;
    logic [4*NUM_DIGITS-1:0] digits_d;
    logic [NUM_DIGITS-1:0]   blank_d;
    logic [NUM_DIGITS-1:0]   seen_d;

    seg7_pattern_decode u_decode (
        .cat (cap_cat),
        .dec (dec)
    );

    // Anode classifier: no active digit is an idle slot between scans,
    // exactly one is a commit, anything else is a wiring/driver fault.
    always_comb begin
        zero_cnt = '0;
        an_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!cap_an[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                an_idx   = 3'(i);
            end
        end
        if (zero_cnt == 4'd0) begin
            an_class = AN_IDLE;
        end else if (zero_cnt == 4'd1) begin
            an_class = AN_ONE;
        end else begin
            an_class = AN_BAD;
        end
    end

    always_comb begin
        commit      = cap_vld && (an_class == AN_ONE);
        new_err_an  = cap_vld && (an_class == AN_BAD);
        new_err_seg = 1'b0;
        frame_done  = 1'b0;
        digits_d    = digits_q;
        blank_d     = blank_q;
        seen_d      = seen;
        if (commit) begin
            // An unknown pattern still counts the digit as visited so a
            // corrupted digit cannot stall frame completion.
            seen_d[an_idx] = 1'b1;
            if (dec.valid) begin
                digits_d[{an_idx, 2'b00} +: 4] = dec.nibble;
                blank_d[an_idx]                = 1'b0;
            end else if (dec.blank) begin
                digits_d[{an_idx, 2'b00} +: 4] = 4'h0;
                blank_d[an_idx]                = 1'b1;
            end else begin
                new_err_seg = 1'b1;
            end
            if (&seen_d) begin
                frame_done = 1'b1;
                seen_d     = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cap_vld     <= 1'b0;
            cap_cat     <= BLANK_PAT;
            cap_an      <= '1;
            digits_q    <= '0;
            blank_q     <= '1;
            seen        <= '0;
            frame_pend  <= 1'b0;
            frame_vld_q <= 1'b0;
            frame_cnt_q <= '0;
            err_an_q    <= 1'b0;
            err_seg_q   <= 1'b0;
        end else begin
            cap_vld <= bus.SAMPLE_CE;
            if (bus.SAMPLE_CE) begin
                cap_cat <= bus.CAT;
                cap_an  <= bus.AN;
            end

            digits_q   <= digits_d;
            blank_q    <= blank_d;
            seen       <= seen_d;
            frame_pend <= frame_done;

            frame_vld_q <= frame_pend;
            if (frame_pend) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end

            // A fresh error in the clearing cycle must not be lost.
            err_an_q  <= (err_an_q  & ~bus.ERR_CLR) | new_err_an;
            err_seg_q <= (err_seg_q & ~bus.ERR_CLR) | new_err_seg;
        end
    end

    assign bus.DIGITS    = digits_q;
    assign bus.BLANK     = blank_q;
    assign bus.FRAME_VLD = frame_vld_q;
    assign bus.FRAME_CNT = frame_cnt_q;
    assign bus.ERR_AN    = err_an_q;
    assign bus.ERR_SEG   = err_seg_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   pulses;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.FRAME_VLD === 1'b1) pulses++;
    end

    typedef struct {
        logic [7:0]  an;
        logic [6:0]  cat;
        logic        clr;
        logic [31:0] exp_digits;
        logic [7:0]  exp_blank;
        logic        exp_err_an;
        logic        exp_err_seg;
    } vec_t;

    vec_t vecs [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sample(input logic [7:0] an, input logic [6:0] cat);
        bus.SAMPLE_CE = 1'b1;
        bus.AN        = an;
        bus.CAT       = cat;
        step();
    endtask

    task automatic idle_cycles(input int n);
        bus.SAMPLE_CE = 1'b0;
        bus.AN        = 8'hFF;
        bus.CAT       = 7'h7F;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_digits"}, bus.DIGITS, 32'h0);
        check({tag, "_blank"},  32'(bus.BLANK), 32'hFF);
        check({tag, "_fvld"},   32'(bus.FRAME_VLD), 32'h0);
        check({tag, "_fcnt"},   32'(bus.FRAME_CNT), 32'h0);
        check({tag, "_err_an"}, 32'(bus.ERR_AN), 32'h0);
        check({tag, "_err_seg"},32'(bus.ERR_SEG), 32'h0);
    endtask

    logic [6:0] frame_cats [8];
    int         p0;

    initial begin
        checks   = 0;
        failures = 0;
        pulses   = 0;

        vecs[0]  = '{8'hFC, 7'h24, 1'b0, 32'h1A22_B022, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{8'hFC, 7'h24, 1'b1, 32'h1A22_B022, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'hFF, 7'h24, 1'b1, 32'h1A22_B022, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{8'hFB, 7'h06, 1'b0, 32'h1A22_BE22, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{8'hFB, 7'h7F, 1'b0, 32'h1A22_B022, 8'h04, 1'b0, 1'b0};
        vecs[5]  = '{8'hFB, 7'h7E, 1'b0, 32'h1A22_B022, 8'h04, 1'b0, 1'b1};
        vecs[6]  = '{8'h7F, 7'h10, 1'b0, 32'h9A22_B022, 8'h04, 1'b0, 1'b1};
        vecs[7]  = '{8'hFF, 7'h7F, 1'b1, 32'h9A22_B022, 8'h04, 1'b0, 1'b0};
        vecs[8]  = '{8'h00, 7'h24, 1'b0, 32'h9A22_B022, 8'h04, 1'b1, 1'b0};
        vecs[9]  = '{8'hBF, 7'h0E, 1'b0, 32'h9F22_B022, 8'h04, 1'b1, 1'b0};
        vecs[10] = '{8'hFF, 7'h00, 1'b1, 32'h9F22_B022, 8'h04, 1'b0, 1'b0};
        vecs[11] = '{8'hEF, 7'h46, 1'b0, 32'h9F2C_B022, 8'h04, 1'b0, 1'b0};
        vecs[12] = '{8'hDF, 7'h21, 1'b0, 32'h9FDC_B022, 8'h04, 1'b0, 1'b0};
        vecs[13] = '{8'hF7, 7'h78, 1'b0, 32'h9FDC_7022, 8'h04, 1'b0, 1'b0};
        vecs[14] = '{8'hFD, 7'h00, 1'b0, 32'h9FDC_7082, 8'h04, 1'b0, 1'b0};
        vecs[15] = '{8'hFE, 7'h12, 1'b0, 32'h9FDC_7085, 8'h04, 1'b0, 1'b0};

        // Reset
        rst           = 1'b0;
        bus.SAMPLE_CE = 1'b0;
        bus.AN        = 8'hFF;
        bus.CAT       = 7'h7F;
        bus.ERR_CLR   = 1'b0;
        step();
        step();
        check_reset_state("reset");
        rst = 1'b1;
        step();

        // Single digit: digit 0 = 2
        sample(8'hFE, 7'h24);
        idle_cycles(1);
        check("single_digits", bus.DIGITS, 32'h0000_0002);
        check("single_blank",  32'(bus.BLANK), 32'hFE);
        check("single_fvld",   32'(pulses), 32'd0);

        // Full frame back-to-back: digits 2,2,0,B,2,2,A,1
        frame_cats = '{7'h24, 7'h24, 7'h40, 7'h03, 7'h24, 7'h24, 7'h08, 7'h79};
        p0 = pulses;
        for (int k = 0; k < 8; k++) sample(~(8'h01 << k), frame_cats[k]);
        idle_cycles(3);
        check("frame_digits", bus.DIGITS, 32'h1A22_B022);
        check("frame_blank",  32'(bus.BLANK), 32'h00);
        check("frame_pulses", 32'(pulses - p0), 32'd1);
        check("frame_cnt",    32'(bus.FRAME_CNT), 32'd1);

        // Table vectors: anode faults, clear priority, blank/unknown codes
        p0 = pulses;
        for (int v = 0; v < 16; v++) begin
            bus.SAMPLE_CE = 1'b1;
            bus.AN        = vecs[v].an;
            bus.CAT       = vecs[v].cat;
            bus.ERR_CLR   = 1'b0;
            step();
            bus.SAMPLE_CE = 1'b0;
            bus.AN        = 8'hFF;
            bus.ERR_CLR   = vecs[v].clr;
            step();
            bus.ERR_CLR   = 1'b0;
            check($sformatf("vec%0d_digits", v), bus.DIGITS, vecs[v].exp_digits);
            check($sformatf("vec%0d_blank", v), 32'(bus.BLANK), 32'(vecs[v].exp_blank));
            check($sformatf("vec%0d_err_an", v), 32'(bus.ERR_AN), 32'(vecs[v].exp_err_an));
            check($sformatf("vec%0d_err_seg", v), 32'(bus.ERR_SEG), 32'(vecs[v].exp_err_seg));
        end
        idle_cycles(2);
        check("table_pulses", 32'(pulses - p0), 32'd1);
        check("table_fcnt",   32'(bus.FRAME_CNT), 32'd2);

        // A frame whose digit 2 is an unknown pattern still completes
        p0 = pulses;
        for (int k = 0; k < 8; k++) sample(~(8'h01 << k), (k == 2) ? 7'h7E : 7'h40);
        idle_cycles(3);
        check("segframe_pulses",  32'(pulses - p0), 32'd1);
        check("segframe_fcnt",    32'(bus.FRAME_CNT), 32'd3);
        check("segframe_digits",  bus.DIGITS, 32'h0);
        check("segframe_blank",   32'(bus.BLANK), 32'h04);
        check("segframe_err_seg", 32'(bus.ERR_SEG), 32'd1);
        bus.ERR_CLR = 1'b1;
        step();
        bus.ERR_CLR = 1'b0;
        check("segframe_clr", 32'(bus.ERR_SEG), 32'd0);

        // Frame counter wrap: 3 + 252 = 255, one more wraps to 0
        p0 = pulses;
        for (int f = 0; f < 252; f++) begin
            for (int k = 0; k < 8; k++) sample(~(8'h01 << k), 7'h40);
        end
        idle_cycles(3);
        check("wrap_fcnt_255", 32'(bus.FRAME_CNT), 32'd255);
        for (int k = 0; k < 8; k++) sample(~(8'h01 << k), 7'h40);
        idle_cycles(3);
        check("wrap_fcnt_0",  32'(bus.FRAME_CNT), 32'd0);
        check("wrap_pulses",  32'(pulses - p0), 32'd253);

        // Reset mid-operation with a pending capture and a partial frame
        for (int k = 0; k < 8; k++) sample(~(8'h01 << k), 7'h40);
        sample(8'hFC, 7'h24);
        for (int k = 1; k < 8; k++) sample(~(8'h01 << k), 7'h79);
        idle_cycles(2);
        check("pre_rst_fcnt",   32'(bus.FRAME_CNT), 32'd1);
        check("pre_rst_err_an", 32'(bus.ERR_AN), 32'd1);
        sample(8'hFE, 7'h30);
        rst           = 1'b0;
        bus.SAMPLE_CE = 1'b1;
        bus.ERR_CLR   = 1'b1;
        step();
        check_reset_state("midrst");
        rst           = 1'b1;
        bus.ERR_CLR   = 1'b0;
        idle_cycles(1);
        check("midrst_no_commit", bus.DIGITS, 32'h0);
        p0 = pulses;
        sample(8'hFE, 7'h30);
        idle_cycles(3);
        check("post_rst_digits", bus.DIGITS, 32'h0000_0003);
        check("post_rst_pulses", 32'(pulses - p0), 32'd0);
        check("post_rst_fcnt",   32'(bus.FRAME_CNT), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Display-side reader for the lab's multiplexed 8-digit 7-segment interface. It samples the scanned cathode/anode lines (CAT/AN) that the digit-entry block drives. It decodes each segment pattern back to a hex nibble and rebuilds the full 8-digit frame as a parallel word. It sits next to the display driver in the verification/self-check path and gives a frame-complete strobe plus sticky error flags.

## Interface
- No parameters; digit count fixed at 8, segment code table fixed (see Structure).
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-low reset.
- SAMPLE_CE  in  1  one-cycle strobe; CAT/AN stable and valid this cycle.
- CAT  in  7  segment lines, active-low, CAT[0]=a … CAT[6]=g.
- AN  in  8  digit anodes, active-low, AN[i] selects digit i.
- ERR_CLR  in  1  one-cycle clear of ERR_AN/ERR_SEG.
- DIGITS  out  32  decoded frame, digit i in DIGITS[4i+3:4i].
- BLANK  out  8  BLANK[i]=1 when digit i was last sampled with all segments off.
- FRAME_VLD  out  1  one-cycle pulse when all 8 digits sampled since last pulse.
- FRAME_CNT  out  8  count of completed frames, wraps 255→0.
- ERR_AN  out  1  sticky: sampled AN had more than one zero.
- ERR_SEG  out  1  sticky: sampled CAT not in code table and not blank.

## Operation
- Segment codes (active-high gfedcba, CAT = bitwise NOT): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Stage 1: on an edge with SAMPLE_CE=1, register CAT, AN and set cap_vld. cap_vld clears on the next edge unless SAMPLE_CE is high again (back-to-back samples allowed).
- Stage 2 (cap_vld=1), classify the registered AN:
  - AN=FF: idle. No update, no error.
  - Exactly one zero at i: commit digit i.
  - Otherwise: set ERR_AN. No digit, BLANK or seen update.
- Commit of digit i, by registered CAT:
  - Valid code: DIGITS nibble i = value, BLANK[i]=0, seen[i]=1.
  - CAT=7F (blank): nibble i = 0, BLANK[i]=1, seen[i]=1.
  - Unknown pattern: nibble i and BLANK[i] unchanged, seen[i]=1, set ERR_SEG.
- Frame tracking: internal seen[7:0]. When a commit makes seen all ones:
  - FRAME_VLD pulses the following cycle.
  - seen is cleared.
  - FRAME_CNT increments.
- Re-sampling an already-seen digit overwrites its nibble and does not end the frame.
- Error flags: ERR_CLR clears both flags. If a new error is detected in the same cycle as ERR_CLR, the set wins.

## Timing
- Reset values: DIGITS=0, BLANK=FF, FRAME_VLD=0, FRAME_CNT=0, ERR_AN=0, ERR_SEG=0, seen=0, cap_vld=0.
- Latency: SAMPLE_CE captured at edge t. DIGITS, BLANK and error flags are updated at edge t+1. FRAME_VLD is high and FRAME_CNT incremented after edge t+2, for exactly one cycle.
- Throughput: one sample per cycle sustained.
- Reset asserted mid-operation: pending cap_vld is discarded and partial frame progress (seen) is lost. Reset dominates ERR_CLR and SAMPLE_CE.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package seg7_pkg: the 16 segment-code constants, the BLANK_PAT constant (7'h7F active-low), and the digit-count constant 8. The display driver imports the same package, so encoder and decoder cannot diverge.
- One sub-module, seg7_pattern_decode: combinational CAT → {valid, blank, nibble[3:0]}. The top holds the capture stage, anode classifier, digit registers, frame tracker and flags.

## Test plan
- Reset: drive RST=0 for 2 cycles. Expect DIGITS=0, BLANK=FF, FRAME_CNT=0, both ERR flags 0.
- Single digit: SAMPLE_CE with AN=FE, CAT=24 (digit 2). Two edges later, DIGITS[3:0]=2, BLANK[0]=0, no FRAME_VLD.
- Full frame: scan AN=FE…7F with digits 2,2,0,B,2,2,A,1 on consecutive strobes. Expect DIGITS=32'h1A22_B022 and exactly one FRAME_VLD pulse. FRAME_CNT=1.
- Anode fault: AN=FC, CAT=24. Expect ERR_AN=1 and DIGITS unchanged. Then assert ERR_CLR in the same cycle a second AN=FC commits: ERR_AN stays 1. ERR_CLR alone on the next cycle clears it.
- Segment cases: AN=FB with CAT=7F gives BLANK[2]=1 and nibble 2 = 0. AN=FB with CAT=7E (only 'a' lit) gives ERR_SEG=1, nibble unchanged, seen[2] set.
- Wrap and reset: complete 256 frames, expect FRAME_CNT=0 after the last pulse. Then assert RST low on the cycle after a SAMPLE_CE: no commit occurs and all outputs return to reset values.
